md_unit: RTL
============

# md_unit

Multi-cycle multiply/divide controller for the E stage of the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations decoded into the MD instruction class. It owns the HI/LO registers and sequences each multi-cycle operation with a countdown counter. It also generates the pipeline stall that holds any later MD-class instruction in D while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- Start  in  1  E-stage MD instruction valid this cycle (already stall/flush qualified)
- MDOp  in  4  operation code (encodings in md_pkg)
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- D_IsMD  in  1  D stage holds an MD-class instruction
- Busy  out  1  multi-cycle operation in flight
- Stall  out  1  D_IsMD & (Busy | (Start & MDOp is MULT/MULTU/DIV/DIVU))
- HI  out  32  HI register
- LO  out  32  LO register
- RData  out  32  MFHI→HI, MFLO→LO, else 0 (combinational from MDOp)

## Operation
- States: IDLE, MUL, DIV (md_pkg enum).
- IDLE with Start:
  - MULT/MULTU → MUL; counter loads MULT_CYCLES; result computed from A, B at this edge and held in shadow HI/LO regs.
  - DIV/DIVU → DIV; counter loads DIV_CYCLES; result likewise held in shadow regs.
  - MTHI: HI←A at this edge, stay IDLE.
  - MTLO: LO←A at this edge, stay IDLE.
  - MFHI/MFLO/other codes: no state change.
- MUL/DIV: counter decrements every edge. At the edge where counter==1: HI/LO←shadow, return to IDLE.
- Start while Busy: ignored. The pipeline guarantees this cannot occur via Stall; the bench checks it is ignored.
- MULT: signed 32×32→64; HI=upper 32 bits, LO=lower 32 bits. MULTU: unsigned.
- DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (B==0): operation still takes DIV_CYCLES, but HI/LO are left unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MFHI/MFLO issued while Busy: they are held by Stall and never sample stale HI/LO.

## Timing
- Reset (async, any time, including mid-operation): state=IDLE, counter=0, HI=LO=0, shadow=0, Busy=0, Stall=0. The in-flight operation is discarded.
- Start sampled at edge E0 for MULT: Busy=1 for cycles E0+1…E0+MULT_CYCLES. At edge E0+MULT_CYCLES, HI/LO update and Busy=0 in the same cycle. DIV is the same with DIV_CYCLES.
- Stall is combinational:
  - Asserted in the Start cycle itself when D holds an MD instruction and E starts a mult/div.
  - Deasserts in the first cycle new HI/LO are visible.
- MTHI/MTLO: new value visible the cycle after Start, with zero stall.
- Back-to-back MD ops: the next Start can occur in the cycle Busy falls.

## Structure
- md_pkg:
  - MDOp encodings: NONE=0, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
  - State enum.
  - Counter width = $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Single module, no sub-module. Arithmetic uses behavioral operators; the countdown counter models latency.

## Test plan
- MULT A=0xFFFFFFFE (−2), B=3 → after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=−7 (0xFFFFFFF9), B=2 → Busy exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- MTHI A=0x12345678, then MFHI the next cycle → RData=0x12345678, Busy and Stall stay 0.
- DIV with B=0 after MTLO 0xAA, MTHI 0x55 → Busy 10 cycles, then HI=0x55, LO=0xAA.
- MULT start with D_IsMD=1 → Stall=1 from the Start cycle through the last busy cycle, 0 when HI/LO update. Start pulse during Busy → ignored, latency unchanged.
- Reset asserted asynchronously in cycle 3 of a DIV → HI=LO=0 and Busy=0 immediately. A following MULT 2×3 gives LO=6 after 5 cycles.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Covers the MDOp encodings, the sequencer state type and the counter sizing helper.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } md_state_e;

    // Wide enough to hold the longer of the two latencies.
    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        int longest;
        longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide controller owning HI/LO for the E stage.
// Results are computed at issue, parked in shadow registers and committed when the countdown expires.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_IsMD,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] RData
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e   state;
    logic [CW-1:0] cnt;
    logic [31:0] hi_sh;
    logic [31:0] lo_sh;
    logic        sh_wr;

    logic        is_muldiv;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow case and
    // gives a truncated quotient with the remainder taking the dividend's sign.
    assign a_mag = A[31] ? -A : A;
    assign b_mag = B[31] ? -B : B;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quo_s = (A[31] ^ B[31]) ? -q_mag : q_mag;
    assign rem_s = A[31] ? -r_mag : r_mag;
    assign quo_u = A / B;
    assign rem_u = A % B;

    assign is_muldiv = (MDOp == MD_MULT) || (MDOp == MD_MULTU) ||
                       (MDOp == MD_DIV)  || (MDOp == MD_DIVU);

    assign Busy  = (state != S_IDLE);
    assign Stall = D_IsMD & (Busy | (Start & is_muldiv));

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        RData = 32'd0;
        if (MDOp == MD_MFHI)
            RData = HI;
        else if (MDOp == MD_MFLO)
            RData = LO;
    end

    // NOTE: the shadow registers are reset along with HI/LO so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            hi_sh <= 32'd0;
            lo_sh <= 32'd0;
            sh_wr <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else if (state == S_IDLE) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            if (Start) begin
                case (MDOp)
                    MD_MULT: begin
                        state <= S_MUL;
                        cnt   <= CW'(MULT_CYCLES);
                        hi_sh <= prod_s[63:32];
                        lo_sh <= prod_s[31:0];
                        sh_wr <= 1'b1;
                    end
                    MD_MULTU: begin
                        state <= S_MUL;
                        cnt   <= CW'(MULT_CYCLES);
                        hi_sh <= prod_u[63:32];
                        lo_sh <= prod_u[31:0];
                        sh_wr <= 1'b1;
                    end
                    MD_DIV: begin
                        state <= S_DIV;
                        cnt   <= CW'(DIV_CYCLES);
                        hi_sh <= rem_s;
                        lo_sh <= quo_s;
                        sh_wr <= (B != 32'd0);
                    end
                    MD_DIVU: begin
                        state <= S_DIV;
                        cnt   <= CW'(DIV_CYCLES);
                        hi_sh <= rem_u;
                        lo_sh <= quo_u;
                        sh_wr <= (B != 32'd0);
                    end
                    MD_MTHI: HI <= A;
                    MD_MTLO: LO <= A;
                    default: ;
                endcase
            end
        end else begin
            // Start is ignored while busy; the pipeline holds it back with Stall.
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state <= S_IDLE;
                if (sh_wr) begin
                    HI <= hi_sh;
                    LO <= lo_sh;
                end
            end
        end
    end

endmodule
